// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: packer FSM states and output word geometry.
package cnn_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FLUSH,
        DONE
    } ofm_packer_state_t;

endpackage

// File: rtl/ofm_lane_reg.sv
// Four-lane byte capture register; word presents the held lanes merged with
// the byte currently offered at idx, unfilled lanes above idx read as zero.
module ofm_lane_reg
    import cnn_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       capture,
    input  logic [7:0] data,
    output logic [1:0] idx,
    output logic [7:0] word [0:BYTES_PER_WORD-1]
);

    logic [7:0] lanes [0:BYTES_PER_WORD-1];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx <= 2'd0;
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                lanes[k] <= 8'h00;
            end
        end else if (capture) begin
            lanes[idx] <= data;
            idx        <= idx + 2'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            word[k] = 8'h00;
            if (2'(k) < idx) begin
                word[k] = lanes[k];
            end else if (2'(k) == idx) begin
                word[k] = data;
            end
        end
    end

endmodule

// File: rtl/ofm_packer.sv
// Packs a run of TOTAL result bytes into 4-byte memory word writes.
// Define OFM_PACKER_FLUSH_EN to write a trailing partial word zero-padded.
module ofm_packer
    import cnn_pkg::*;
#(
    parameter int WIDTH = 172,
    parameter int TOTAL = 172
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   in_valid,
    input  logic [7:0]                             in_data,
    output logic                                   in_ready,
    output logic                                   wr_en,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] wr_addr,
    output logic [7:0]                             wr_data [0:BYTES_PER_WORD-1],
    output logic                                   done,
    output logic                                   busy
);

    localparam int ADDR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W  = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0]  LAST      = CNT_W'(TOTAL - 1);
    localparam logic [ADDR_W:0]   WORD_STEP = (ADDR_W + 1)'(BYTES_PER_WORD);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(WIDTH);

    ofm_packer_state_t state, state_next;

    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   base_plus;
    logic [ADDR_W-1:0] base_next;
    logic [1:0]        idx;
    logic [7:0]        word [0:BYTES_PER_WORD-1];
    logic              start_go;
    logic              accept;
    logic              last;
    logic              emit;

    assign start_go  = start && (state == IDLE || state == DONE);
    assign accept    = in_valid && (state == FILL);
    assign last      = (cnt == LAST);
    assign base_plus = {1'b0, base} + WORD_STEP;
    assign base_next = (base_plus >= DEPTH) ? '0 : base_plus[ADDR_W-1:0];

`ifdef OFM_PACKER_FLUSH_EN
    // The padded tail word is registered on the final handshake so it is on
    // the bus during the single FLUSH cycle.
    assign emit = accept && (idx == 2'd3 || last);
`else
    assign emit = accept && (idx == 2'd3);
`endif

    ofm_lane_reg u_lanes (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_go),
        .capture (accept),
        .data    (in_data),
        .idx     (idx),
        .word    (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = FILL;
            FILL: begin
                if (accept && last) begin
                    state_next = (idx == 2'd3) ? DONE : FLUSH;
                end
            end
            FLUSH:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == FILL);
        busy     = (state == FILL) || (state == FLUSH);
        done     = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            base    <= '0;
            cnt     <= '0;
            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                wr_data[k] <= 8'h00;
            end
        end else begin
            wr_en <= 1'b0;
            if (start_go) begin
                cnt  <= '0;
                base <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
                if (emit) begin
                    wr_en   <= 1'b1;
                    wr_addr <= base;
                    wr_data <= word;
                    base    <= base_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_ofm_packer.sv
// Scoreboard bench: three packers (TOTAL 8, 6, 4) share the byte stream and
// each is started on its own; expected writes are queued as bytes are driven.
module tb_ofm_packer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       start8, start6, start4;

    logic       in_ready8, wr_en8, done8, busy8;
    logic [3:0] wr_addr8;
    logic [7:0] wr_data8 [0:3];
    logic       in_ready6, wr_en6, done6, busy6;
    logic [3:0] wr_addr6;
    logic [7:0] wr_data6 [0:3];
    logic       in_ready4, wr_en4, done4, busy4;
    logic [7:0] wr_addr4;
    logic [7:0] wr_data4 [0:3];

    logic [39:0] q8 [$];
    logic [39:0] q6 [$];
    logic [39:0] q4 [$];

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ofm_packer #(.WIDTH(16), .TOTAL(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready8), .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .done(done8), .busy(busy8)
    );

    ofm_packer #(.WIDTH(16), .TOTAL(6)) u6 (
        .clk(clk), .rst(rst), .start(start6), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready6), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
        .done(done6), .busy(busy6)
    );

    ofm_packer #(.TOTAL(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .done(done4), .busy(busy4)
    );

    function automatic logic [39:0] pk(input logic [7:0] a, input logic [7:0] b0,
                                       input logic [7:0] b1, input logic [7:0] b2,
                                       input logic [7:0] b3);
        return {a, b0, b1, b2, b3};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            passes++;
        end
    endtask

    // Each write strobe is matched against the next queued expectation.
    always @(negedge clk) begin
        if (wr_en8) begin
            if (q8.size() == 0) checkOutput("u8_unexpected_wr", 1, 0);
            else checkOutput("u8_wr", pk({4'b0, wr_addr8}, wr_data8[0], wr_data8[1], wr_data8[2], wr_data8[3]), q8.pop_front());
        end
        if (wr_en6) begin
            if (q6.size() == 0) checkOutput("u6_unexpected_wr", 1, 0);
            else checkOutput("u6_wr", pk({4'b0, wr_addr6}, wr_data6[0], wr_data6[1], wr_data6[2], wr_data6[3]), q6.pop_front());
        end
        if (wr_en4) begin
            if (q4.size() == 0) checkOutput("u4_unexpected_wr", 1, 0);
            else checkOutput("u4_wr", pk(wr_addr4, wr_data4[0], wr_data4[1], wr_data4[2], wr_data4[3]), q4.pop_front());
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulseStart(input int which);
        start8 = (which == 8);
        start6 = (which == 6);
        start4 = (which == 4);
        @(posedge clk); #1;
        start8 = 1'b0;
        start6 = 1'b0;
        start4 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        start8 = 1'b0; start6 = 1'b0; start4 = 1'b0;
        idleCycles(3);
        checkOutput("rst_ctrl8", {in_ready8, wr_en8, done8, busy8}, 4'b0000);
        checkOutput("rst_bus8", pk({4'b0, wr_addr8}, wr_data8[0], wr_data8[1], wr_data8[2], wr_data8[3]), 40'h0);
        rst = 1'b0;
        idleCycles(1);

        // Two full words back-to-back, done coincides with second write.
        pulseStart(8);
        checkOutput("u8_fill_flags", {in_ready8, busy8, done8}, 3'b110);
        q8.push_back(pk(8'h00, 8'h01, 8'h02, 8'h03, 8'h04));
        q8.push_back(pk(8'h04, 8'h05, 8'h06, 8'h07, 8'h08));
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'(i));
            if (i == 4) checkOutput("u8_wr_after_4th", wr_en8, 1);
            if (i == 5) checkOutput("u8_no_wr_after_5th", wr_en8, 0);
        end
        checkOutput("u8_done_with_wr", {wr_en8, done8, busy8, in_ready8}, 4'b1100);
        idleCycles(3);
        checkOutput("u8_done_hold", {done8, wr_en8}, 2'b10);
        checkOutput("u8_bus_hold", pk({4'b0, wr_addr8}, wr_data8[0], wr_data8[1], wr_data8[2], wr_data8[3]),
                    pk(8'h04, 8'h05, 8'h06, 8'h07, 8'h08));

        // Restart drops done; a start pulse mid-run must not rewind the address.
        pulseStart(8);
        checkOutput("u8_restart_flags", {done8, busy8}, 2'b01);
        q8.push_back(pk(8'h00, 8'h11, 8'h12, 8'h13, 8'h14));
        q8.push_back(pk(8'h04, 8'h15, 8'h16, 8'h17, 8'h18));
        applyStimulus(8'h11);
        applyStimulus(8'h12);
        start8 = 1'b1;
        applyStimulus(8'h13);
        start8 = 1'b0;
        for (int i = 4; i <= 8; i++) applyStimulus(8'h10 + 8'(i));
        checkOutput("u8_done_run2", done8, 1);

        // Six bytes: one full word, then a partial tail handled by FLUSH.
        pulseStart(6);
        q6.push_back(pk(8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4));
`ifdef OFM_PACKER_FLUSH_EN
        q6.push_back(pk(8'h04, 8'hA5, 8'hA6, 8'h00, 8'h00));
`endif
        for (int i = 1; i <= 6; i++) applyStimulus(8'hA0 + 8'(i));
`ifdef OFM_PACKER_FLUSH_EN
        checkOutput("u6_flush_cycle", {busy6, done6, wr_en6}, 3'b101);
`else
        checkOutput("u6_flush_cycle", {busy6, done6, wr_en6}, 3'b100);
`endif
        idleCycles(1);
        checkOutput("u6_done_after_flush", {busy6, done6, wr_en6}, 3'b010);

        // Gapped handshakes; the write must follow the 4th byte by one cycle.
        pulseStart(4);
        q4.push_back(pk(8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4));
        applyStimulus(8'hC1);
        idleCycles(1);
        applyStimulus(8'hC2);
        idleCycles(2);
        applyStimulus(8'hC3);
        checkOutput("u4_no_early_wr", wr_en4, 0);
        idleCycles(1);
        applyStimulus(8'hC4);
        checkOutput("u4_wr_and_done", {wr_en4, done4}, 2'b11);
        idleCycles(1);
        checkOutput("u4_wr_single", wr_en4, 0);
        applyStimulus(8'hEE);
        checkOutput("u4_ignore_valid_in_done", {done4, busy4, wr_en4}, 3'b100);

        // Abort after three bytes, with start held alongside rst.
        pulseStart(4);
        applyStimulus(8'hB1);
        applyStimulus(8'hB2);
        applyStimulus(8'hB3);
        rst = 1'b1;
        start4 = 1'b1;
        idleCycles(1);
        rst = 1'b0;
        start4 = 1'b0;
        checkOutput("u4_rst_ctrl", {in_ready4, wr_en4, done4, busy4}, 4'b0000);
        checkOutput("u4_rst_bus", pk(wr_addr4, wr_data4[0], wr_data4[1], wr_data4[2], wr_data4[3]), 40'h0);
        pulseStart(4);
        q4.push_back(pk(8'h00, 8'hD1, 8'hD2, 8'hD3, 8'hD4));
        for (int i = 1; i <= 4; i++) applyStimulus(8'hD0 + 8'(i));
        checkOutput("u4_done_after_rst", {wr_en4, done4}, 2'b11);
        idleCycles(2);

        checkOutput("q8_drained", q8.size(), 0);
        checkOutput("q6_drained", q6.size(), 0);
        checkOutput("q4_drained", q4.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
